operand_serializer: RTL

//  Upstream feeder for the 12-lane square12 shift_register/compressor pair.

---
 rtl/operand_serializer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/operand_serializer.sv
// Parallel-to-serial feeder for a 12-lane shift-register/compressor pair.
// Shifts each accepted operand set out MSB-first and flags when downstream holds it.
module operand_serializer #(
  parameter int WIDTH = 12,
  parameter int TAG_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [12*WIDTH-1:0]   in_data,
  output logic                  src0_,
  output logic                  src1_,
  output logic                  src2_,
  output logic                  src3_,
  output logic                  src4_,
  output logic                  src5_,
  output logic                  src6_,
  output logic                  src7_,
  output logic                  src8_,
  output logic                  src9_,
  output logic                  src10_,
  output logic                  src11_,
  output logic                  busy,
  output logic                  sample_valid,
  output logic [TAG_W-1:0]      sample_tag
);

  localparam int LANES = 12;
  localparam int CW    = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [LANES-1:0][WIDTH-1:0]   shadow_q, shadow_d;
  logic [LANES-1:0]              src_q, src_d;
  logic [TAG_W-1:0]              seq_q, seq_d;
  logic [TAG_W-1:0]              tag_q, tag_d;
  logic                          sample_valid_q, sample_valid_d;
  logic [TAG_W-1:0]              sample_tag_q, sample_tag_d;

  logic [LANES-1:0][WIDTH-1:0]   inLanes;
  logic [CW-1:0]                 nextBit;
  logic                          accept;
  logic                          lastBit;

  assign inLanes  = in_data;
  assign nextBit  = cnt_q - CW'(1);
  assign lastBit  = (state_q == SHIFT) && (cnt_q == '0);
  assign in_ready = rst_n && ((state_q == IDLE) || lastBit);
  assign accept   = in_valid && in_ready;

  // A final-bit edge with a pending accept reloads directly, so sets stream without a gap.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shadow_d       = shadow_q;
    src_d          = src_q;
    seq_d          = seq_q;
    tag_d          = tag_q;
    sample_valid_d = 1'b0;
    sample_tag_d   = sample_tag_q;

    if (lastBit) begin
      sample_valid_d = 1'b1;
      sample_tag_d   = tag_q;
    end

    if (accept) begin
      shadow_d = inLanes;
      for (int i = 0; i < LANES; i++) begin
        src_d[i] = inLanes[i][WIDTH-1];
      end
      cnt_d   = CW'(WIDTH - 1);
      state_d = SHIFT;
      tag_d   = seq_q;
      seq_d   = seq_q + TAG_W'(1);
    end else if (state_q == SHIFT) begin
      if (cnt_q != '0) begin
        for (int i = 0; i < LANES; i++) begin
          src_d[i] = shadow_q[i][nextBit];
        end
        cnt_d = nextBit;
      end else begin
        src_d   = '0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shadow_q       <= '0;
      src_q          <= '0;
      seq_q          <= '0;
      tag_q          <= '0;
      sample_valid_q <= 1'b0;
      sample_tag_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      src_q          <= src_d;
      seq_q          <= seq_d;
      tag_q          <= tag_d;
      sample_valid_q <= sample_valid_d;
      sample_tag_q   <= sample_tag_d;
    end
  end

  assign busy         = (state_q == SHIFT);
  assign sample_valid = sample_valid_q;
  assign sample_tag   = sample_tag_q;

  assign src0_  = src_q[0];
  assign src1_  = src_q[1];
  assign src2_  = src_q[2];
  assign src3_  = src_q[3];
  assign src4_  = src_q[4];
  assign src5_  = src_q[5];
  assign src6_  = src_q[6];
  assign src7_  = src_q[7];
  assign src8_  = src_q[8];
  assign src9_  = src_q[9];
  assign src10_ = src_q[10];
  assign src11_ = src_q[11];

endmodule
